// File: rtl/spi_master.sv
// SPI master, mode 0 (sck idle low, sample on rising, shift on falling), MSB first.
// Optional active-low chip select output cs_n when SPI_MASTER_CS_EN is defined.
module spi_master #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned HALF  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] d,
    input  logic             sdi,
    output logic             sck,
    output logic             sdo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q
`ifdef SPI_MASTER_CS_EN
    ,
    output logic             cs_n
`endif
);

    localparam int unsigned HCW = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int unsigned BCW = $clog2(WIDTH + 1);
    localparam logic [HCW-1:0] HalfLast = HCW'(HALF - 1);
    localparam logic [BCW-1:0] BitLast  = BCW'(WIDTH - 1);

    typedef enum logic {
        StIdle,
        StShift
    } state_e;

    state_e           state_q;
    logic [HCW-1:0]   hcnt_q;
    logic [BCW-1:0]   bcnt_q;
    logic [WIDTH-1:0] tx_q;
    logic [WIDTH-1:0] rx_q;
    logic [WIDTH-1:0] q_q;
    logic             sck_q;
    logic             sdo_q;
    logic             busy_q;
    logic             done_q;
`ifdef SPI_MASTER_CS_EN
    logic             cs_n_q;
`endif

    logic half_tick;
    logic sck_rise;
    logic sck_fall;

    // sck toggles on the edge where the half-period counter has reached HALF-1
    always_comb begin
        half_tick = (hcnt_q == HalfLast);
        sck_rise  = (state_q == StShift) && half_tick && !sck_q;
        sck_fall  = (state_q == StShift) && half_tick && sck_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            hcnt_q  <= '0;
            bcnt_q  <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            q_q     <= '0;
            sck_q   <= 1'b0;
            sdo_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SPI_MASTER_CS_EN
            cs_n_q  <= 1'b1;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        tx_q    <= d;
                        rx_q    <= '0;
                        sdo_q   <= d[WIDTH-1];
                        busy_q  <= 1'b1;
                        sck_q   <= 1'b0;
                        hcnt_q  <= '0;
                        bcnt_q  <= '0;
                        state_q <= StShift;
`ifdef SPI_MASTER_CS_EN
                        cs_n_q  <= 1'b0;
`endif
                    end
                end
                StShift: begin
                    hcnt_q <= half_tick ? '0 : hcnt_q + 1'b1;
                    if (half_tick) begin
                        sck_q <= ~sck_q;
                    end
                    if (sck_rise) begin
                        rx_q <= {rx_q[WIDTH-2:0], sdi};
                    end
                    if (sck_fall) begin
                        bcnt_q <= bcnt_q + 1'b1;
                        if (bcnt_q == BitLast) begin
                            // Final falling edge: publish rx and release the bus
                            q_q     <= rx_q;
                            sdo_q   <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= StIdle;
`ifdef SPI_MASTER_CS_EN
                            cs_n_q  <= 1'b1;
`endif
                        end else begin
                            tx_q  <= {tx_q[WIDTH-2:0], 1'b0};
                            sdo_q <= tx_q[WIDTH-2];
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign sck  = sck_q;
    assign sdo  = sdo_q;
    assign busy = busy_q;
    assign done = done_q;
    assign q    = q_q;
`ifdef SPI_MASTER_CS_EN
    assign cs_n = cs_n_q;
`endif

endmodule
